// File: rtl/sprite_frame_scheduler.sv
// Frame-synchronous box scheduler and IDLE/PLAY/WIN sequencer for the VGA overlay.
// Bounds are committed once per frame at the blanking edge; target updates arrive through a one-deep slot.
module sprite_frame_scheduler #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int PLAYER_HALF = 25,
    parameter int TARGET_HALF = 30,
    parameter int HOLD_FRAMES = 60
) (
    input  logic        clk_25mHz,
    input  logic        reset,
    input  logic        screen_end,
    input  logic        start,
    input  logic [9:0]  player_x,
    input  logic [8:0]  player_y,
    input  logic        tgt_valid,
    input  logic [9:0]  tgt_x,
    input  logic [8:0]  tgt_y,
    output logic        tgt_ready,
    output logic [9:0]  player_left,
    output logic [9:0]  player_right,
    output logic [8:0]  player_top,
    output logic [8:0]  player_bottom,
    output logic [9:0]  target_left,
    output logic [9:0]  target_right,
    output logic [8:0]  target_top,
    output logic [8:0]  target_bottom,
    output logic [7:0]  hold_count,
    output logic        win,
    output logic        new_target_req,
    output logic [31:0] game_state
);

    localparam logic [9:0] P_HX   = 10'(PLAYER_HALF);
    localparam logic [8:0] P_HY   = 9'(PLAYER_HALF);
    localparam logic [9:0] P_X_HI = 10'(WIDTH - 1 - PLAYER_HALF);
    localparam logic [8:0] P_Y_HI = 9'(HEIGHT - 1 - PLAYER_HALF);
    localparam logic [9:0] T_HX   = 10'(TARGET_HALF);
    localparam logic [8:0] T_HY   = 9'(TARGET_HALF);
    localparam logic [9:0] T_X_HI = 10'(WIDTH - 1 - TARGET_HALF);
    localparam logic [8:0] T_Y_HI = 9'(HEIGHT - 1 - TARGET_HALF);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2
    } state_t;

    function automatic logic [9:0] clamp_x(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] hi);
        logic [9:0] r;
        if (v < lo) r = lo;
        else if (v > hi) r = hi;
        else r = v;
        return r;
    endfunction

    function automatic logic [8:0] clamp_y(input logic [8:0] v, input logic [8:0] lo, input logic [8:0] hi);
        logic [8:0] r;
        if (v < lo) r = lo;
        else if (v > hi) r = hi;
        else r = v;
        return r;
    endfunction

    state_t     state_r;
    logic       se_q_r, armed_r, tick_r, eval_r;
    logic       slot_full_r, tgt_ready_r;
    logic [9:0] slot_x_r;
    logic [8:0] slot_y_r;
    logic [9:0] pl_r, pr_r, tl_r, tr_r;
    logic [8:0] pt_r, pb_r, tt_r, tb_r;
    logic [7:0] hold_r;
    logic       win_r, ntr_r;
    logic [9:0] pcx_s, tcx_s;
    logic [8:0] pcy_s, tcy_s;
    logic       inside_s;

    // Clamped centres and containment test on the committed bounds.
    always_comb begin
        pcx_s    = clamp_x(player_x, P_HX, P_X_HI);
        pcy_s    = clamp_y(player_y, P_HY, P_Y_HI);
        tcx_s    = clamp_x(slot_x_r, T_HX, T_X_HI);
        tcy_s    = clamp_y(slot_y_r, T_HY, T_Y_HI);
        inside_s = (pl_r >= tl_r) && (pr_r <= tr_r) && (pt_r >= tt_r) && (pb_r <= tb_r);
    end

    // Frame tick; armed_r suppresses a tick for a screen_end already high at reset release.
    always_ff @(posedge clk_25mHz) begin
        if (!reset) begin
            se_q_r  <= 1'b0;
            armed_r <= 1'b0;
            tick_r  <= 1'b0;
            eval_r  <= 1'b0;
        end else begin
            se_q_r  <= screen_end;
            armed_r <= 1'b1;
            tick_r  <= armed_r & screen_end & ~se_q_r;
            eval_r  <= tick_r;
        end
    end

    // One-deep target slot; a tick drains it before any new value may enter.
    always_ff @(posedge clk_25mHz) begin
        if (!reset) begin
            slot_full_r <= 1'b0;
            tgt_ready_r <= 1'b0;
            slot_x_r    <= 10'd0;
            slot_y_r    <= 9'd0;
        end else if (tick_r && slot_full_r) begin
            slot_full_r <= 1'b0;
            tgt_ready_r <= 1'b1;
        end else if (tgt_valid && tgt_ready_r) begin
            slot_full_r <= 1'b1;
            tgt_ready_r <= 1'b0;
            slot_x_r    <= tgt_x;
            slot_y_r    <= tgt_y;
        end else begin
            tgt_ready_r <= ~slot_full_r;
        end
    end

    // Bounds commit on the tick cycle only.
    always_ff @(posedge clk_25mHz) begin
        if (!reset) begin
            pl_r <= 10'd0; pr_r <= 10'd0; pt_r <= 9'd0; pb_r <= 9'd0;
            tl_r <= 10'd0; tr_r <= 10'd0; tt_r <= 9'd0; tb_r <= 9'd0;
        end else if (tick_r) begin
            pl_r <= pcx_s - P_HX;
            pr_r <= pcx_s + P_HX;
            pt_r <= pcy_s - P_HY;
            pb_r <= pcy_s + P_HY;
            if (slot_full_r) begin
                tl_r <= tcx_s - T_HX;
                tr_r <= tcx_s + T_HX;
                tt_r <= tcy_s - T_HY;
                tb_r <= tcy_s + T_HY;
            end else begin
                tl_r <= tl_r; tr_r <= tr_r; tt_r <= tt_r; tb_r <= tb_r;
            end
        end else begin
            pl_r <= pl_r; pr_r <= pr_r; pt_r <= pt_r; pb_r <= pb_r;
        end
    end

    // Game sequencer; start is only honoured outside PLAY, so it naturally wins over eval.
    always_ff @(posedge clk_25mHz) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            hold_r  <= 8'd0;
            win_r   <= 1'b0;
            ntr_r   <= 1'b0;
        end else begin
            win_r <= 1'b0;
            ntr_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_PLAY;
                        hold_r  <= 8'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (eval_r && inside_s) begin
                        hold_r <= (hold_r == 8'hFF) ? 8'hFF : hold_r + 8'd1;
                        if (hold_r == HOLD_LAST) begin
                            state_r <= ST_WIN;
                            win_r   <= 1'b1;
                        end else begin
                            state_r <= ST_PLAY;
                        end
                    end else if (eval_r) begin
                        hold_r <= 8'd0;
                    end else begin
                        hold_r <= hold_r;
                    end
                end
                ST_WIN: begin
                    if (start) begin
                        state_r <= ST_PLAY;
                        hold_r  <= 8'd0;
                        ntr_r   <= 1'b1;
                    end else begin
                        state_r <= ST_WIN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    hold_r  <= 8'd0;
                end
            endcase
        end
    end

    assign tgt_ready      = tgt_ready_r;
    assign player_left    = pl_r;
    assign player_right   = pr_r;
    assign player_top     = pt_r;
    assign player_bottom  = pb_r;
    assign target_left    = tl_r;
    assign target_right   = tr_r;
    assign target_top     = tt_r;
    assign target_bottom  = tb_r;
    assign hold_count     = hold_r;
    assign win            = win_r;
    assign new_target_req = ntr_r;
    assign game_state     = {30'd0, state_r};

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Scoreboard bench for sprite_frame_scheduler: expected frame results are queued when a frame is
// driven and compared when the DUT commits bounds (E+2) and game state (E+3).
module tb_sprite_frame_scheduler;

    localparam int W = 640, H = 480, PH = 25, TH = 30, HOLD = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        screen_end = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  player_x = 10'd0;
    logic [8:0]  player_y = 9'd0;
    logic        tgt_valid = 1'b0;
    logic [9:0]  tgt_x = 10'd0;
    logic [8:0]  tgt_y = 9'd0;
    logic        tgt_ready;
    logic [9:0]  player_left, player_right, target_left, target_right;
    logic [8:0]  player_top, player_bottom, target_top, target_bottom;
    logic [7:0]  hold_count;
    logic        win, new_target_req;
    logic [31:0] game_state;

    sprite_frame_scheduler dut (
        .clk_25mHz(clk), .reset(reset), .screen_end(screen_end), .start(start),
        .player_x(player_x), .player_y(player_y),
        .tgt_valid(tgt_valid), .tgt_x(tgt_x), .tgt_y(tgt_y), .tgt_ready(tgt_ready),
        .player_left(player_left), .player_right(player_right),
        .player_top(player_top), .player_bottom(player_bottom),
        .target_left(target_left), .target_right(target_right),
        .target_top(target_top), .target_bottom(target_bottom),
        .hold_count(hold_count), .win(win), .new_target_req(new_target_req),
        .game_state(game_state)
    );

    always #20 clk = ~clk;

    typedef struct {
        int pl, pr, pt, pb, tl, tr, tt, tb;
        int hold, state, win;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    int m_tl = 0, m_tr = 0, m_tt = 0, m_tb = 0;
    int m_slot_full = 0, m_sx = 0, m_sy = 0;
    int m_state = 0, m_hold = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int x, input int y);
        int n;
        n = 0;
        tgt_x = 10'(x);
        tgt_y = 9'(y);
        while (tgt_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_eq("offer_ready", 32'(tgt_ready), 32'd1);
        tgt_valid = 1'b1;
        step();
        tgt_valid = 1'b0;
        check_eq("ready_after_accept", 32'(tgt_ready), 32'd0);
        m_slot_full = 1; m_sx = x; m_sy = y;
    endtask

    task automatic frame();
        exp_t e, g;
        int px, py, tx, ty, ins;
        px = clampi(int'(player_x), PH, W - 1 - PH);
        py = clampi(int'(player_y), PH, H - 1 - PH);
        e.pl = px - PH; e.pr = px + PH; e.pt = py - PH; e.pb = py + PH;
        if (m_slot_full != 0) begin
            tx = clampi(m_sx, TH, W - 1 - TH);
            ty = clampi(m_sy, TH, H - 1 - TH);
            m_tl = tx - TH; m_tr = tx + TH; m_tt = ty - TH; m_tb = ty + TH;
            m_slot_full = 0;
        end
        e.tl = m_tl; e.tr = m_tr; e.tt = m_tt; e.tb = m_tb;
        e.win = 0;
        if (m_state == 1) begin
            ins = (e.pl >= e.tl && e.pr <= e.tr && e.pt >= e.tt && e.pb <= e.tb) ? 1 : 0;
            if (ins != 0) begin
                if (m_hold == HOLD - 1) begin
                    m_state = 2;
                    e.win = 1;
                end
                m_hold = (m_hold == 255) ? 255 : m_hold + 1;
            end else begin
                m_hold = 0;
            end
        end
        e.hold = m_hold; e.state = m_state;
        exp_q.push_back(e);

        screen_end = 1'b1;          // cycle E
        step();                     // E+1: tick
        step();                     // E+2: bounds visible
        g = exp_q.pop_front();
        check_eq("player_left",   32'(player_left),   32'(g.pl));
        check_eq("player_right",  32'(player_right),  32'(g.pr));
        check_eq("player_top",    32'(player_top),    32'(g.pt));
        check_eq("player_bottom", 32'(player_bottom), 32'(g.pb));
        check_eq("target_left",   32'(target_left),   32'(g.tl));
        check_eq("target_right",  32'(target_right),  32'(g.tr));
        check_eq("target_top",    32'(target_top),    32'(g.tt));
        check_eq("target_bottom", 32'(target_bottom), 32'(g.tb));
        step();                     // E+3: state visible
        check_eq("hold_count", 32'(hold_count), 32'(g.hold));
        check_eq("game_state", game_state,      32'(g.state));
        check_eq("win",        32'(win),        32'(g.win));
        screen_end = 1'b0;
        step();
        check_eq("win_one_cycle", 32'(win), 32'd0);
    endtask

    initial begin
        // Reset and first commit
        repeat (3) step();
        check_eq("rst_ready", 32'(tgt_ready), 32'd0);
        check_eq("rst_state", game_state, 32'd0);
        check_eq("rst_pleft", 32'(player_left), 32'd0);
        check_eq("rst_hold", 32'(hold_count), 32'd0);
        reset = 1'b1;
        step();
        check_eq("ready_after_release", 32'(tgt_ready), 32'd1);
        player_x = 10'd320; player_y = 9'd240;
        offer(320, 240);
        frame();

        // Clamping at screen edges
        player_x = 10'd5; player_y = 9'd470;
        offer(635, 2);
        frame();

        // Second offer while the slot is full waits for the tick to drain it
        player_x = 10'd320; player_y = 9'd240;
        offer(320, 240);
        tgt_x = 10'd100; tgt_y = 9'd200; tgt_valid = 1'b1;
        step();
        check_eq("ready_full_1", 32'(tgt_ready), 32'd0);
        step();
        check_eq("ready_full_2", 32'(tgt_ready), 32'd0);
        frame();
        check_eq("ready_refilled", 32'(tgt_ready), 32'd0);
        tgt_valid = 1'b0;
        m_slot_full = 1; m_sx = 100; m_sy = 200;
        frame();
        offer(320, 240);
        frame();

        // Play: a miss on frame 30 clears the count
        start = 1'b1; step(); start = 1'b0;
        m_state = 1; m_hold = 0;
        check_eq("start_state", game_state, 32'd1);
        check_eq("start_hold", 32'(hold_count), 32'd0);
        repeat (29) frame();
        player_x = 10'd50; player_y = 9'd50;
        frame();
        check_eq("miss_hold", 32'(hold_count), 32'd0);
        player_x = 10'd320; player_y = 9'd240;
        start = 1'b1; step(); start = 1'b0;
        check_eq("start_ignored_in_play", game_state, 32'd1);
        repeat (HOLD) frame();
        check_eq("win_state", game_state, 32'd2);

        // Restart from WIN
        start = 1'b1; step(); start = 1'b0;
        m_state = 1; m_hold = 0;
        check_eq("restart_state", game_state, 32'd1);
        check_eq("restart_req", 32'(new_target_req), 32'd1);
        check_eq("restart_hold", 32'(hold_count), 32'd0);
        step();
        check_eq("restart_req_one_cycle", 32'(new_target_req), 32'd0);

        // Reset with slot full and screen_end high; release while still high
        offer(200, 200);
        screen_end = 1'b1; reset = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        check_eq("mid_rst_ready", 32'(tgt_ready), 32'd1);
        check_eq("mid_rst_state", game_state, 32'd0);
        step(); step();
        check_eq("mid_rst_pleft", 32'(player_left), 32'd0);
        check_eq("mid_rst_tright", 32'(target_right), 32'd0);
        check_eq("mid_rst_pbottom", 32'(player_bottom), 32'd0);
        screen_end = 1'b0;
        step();
        m_slot_full = 0; m_tl = 0; m_tr = 0; m_tt = 0; m_tb = 0;
        m_state = 0; m_hold = 0;
        frame();
        check_eq("post_rst_ready", 32'(tgt_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_frame_scheduler.md
# sprite_frame_scheduler

Frame-synchronous scheduler and game sequencer for the VGA box overlay. It runs in the 25 MHz pixel-clock domain beside the timing generator. Once per frame, at the blanking edge, it commits player and target box bounds so the overlay never tears mid-frame. It also accepts target-position updates from the processor through a one-deep valid/ready slot, and it runs the IDLE/PLAY/WIN state machine that produces `game_state`.

## Interface

**Parameters**
- WIDTH, 640: visible pixels per line.
- HEIGHT, 480: visible lines.
- PLAYER_HALF, 25: player box half-size, in pixels.
- TARGET_HALF, 30: target box half-size, in pixels.
- HOLD_FRAMES, 60: consecutive inside-frames needed to win (1..255).

**Ports**
- clk_25mHz, input, 1: pixel clock. This is the only clock.
- reset, input, 1: synchronous, active-low reset.
- screen_end, input, 1: high while between frames, from the timing generator.
- start, input, 1: single-cycle start/restart request.
- player_x, input, 10: player centre x, sampled live.
- player_y, input, 9: player centre y, sampled live.
- tgt_valid, input, 1: target update offered.
- tgt_x, input, 10: offered target centre x.
- tgt_y, input, 9: offered target centre y.
- tgt_ready, output, 1: pending slot is empty.
- player_left, player_right, output, 10 each: committed player x-bounds.
- player_top, player_bottom, output, 9 each: committed player y-bounds.
- target_left, target_right, output, 10 each: committed target x-bounds.
- target_top, target_bottom, output, 9 each: committed target y-bounds.
- hold_count, output, 8: consecutive inside-frames so far.
- win, output, 1: one-cycle pulse on entering WIN.
- new_target_req, output, 1: one-cycle pulse on restart from WIN.
- game_state, output, 32: 0 = IDLE, 1 = PLAY, 2 = WIN, zero-extended.

## Operation

**Frame tick**
- `se_q` holds `screen_end` delayed by one cycle.
- `tick` is a register set for one cycle after `screen_end & ~se_q` is seen.
- `screen_end` held high produces exactly one tick.

**Commit (tick cycle)**
- Player centre is clamped: x to [PLAYER_HALF, WIDTH-1-PLAYER_HALF], y to [PLAYER_HALF, HEIGHT-1-PLAYER_HALF].
- Player bounds are set to centre ± PLAYER_HALF. Because of the clamp, no bound wraps and all fit their width.
- If the pending slot is full, the target centre is clamped the same way using TARGET_HALF, the target bounds are loaded, and the slot is emptied.
- If the slot is empty, the target bounds are held.

**Pending slot**
- `tgt_ready` is 1 exactly when the slot is empty.
- A transfer happens when `tgt_valid & tgt_ready` is high at a clock edge. The slot then fills and `tgt_ready` drops on the next cycle.
- Valid and tick in the same cycle with the slot full: the tick drains the old value, `tgt_ready` is 0 that cycle, and the new value is accepted in a later cycle.
- Valid and tick in the same cycle with the slot empty: the value is accepted and committed at the next tick. There is no bypass.
- `tgt_x`/`tgt_y` must stay stable while `tgt_valid` is high and `tgt_ready` is low.

**Inside test**
- `inside` = `player_left >= target_left && player_right <= target_right && player_top >= target_top && player_bottom <= target_bottom`.
- It is computed from the committed bounds.

**State machine** (evaluated in the eval cycle, T+1 after tick)
- IDLE:
  - `start` → PLAY, `hold_count` = 0.
  - Commits continue while idle.
- PLAY:
  - On eval, if `inside`, `hold_count` += 1 (saturating at 255); otherwise `hold_count` = 0.
  - If `inside` and `hold_count` == HOLD_FRAMES-1 → WIN, with `win` pulsed.
- WIN:
  - `hold_count` is held.
  - `start` → PLAY with `hold_count` = 0 and `new_target_req` pulsed in the same cycle.
- A `start` arriving in an eval cycle takes priority over the eval result.
- `start` while in PLAY is ignored.

## Timing

**Reset** (`reset` low at an edge)
- State = IDLE and `game_state` = 0.
- All bounds = 0 and `hold_count` = 0.
- Slot is empty, but `tgt_ready` = 0 while reset is low; it goes to 1 on the first cycle after release.
- `tick`, eval, `win` and `new_target_req` = 0. `se_q` = 0.
- Reset asserted mid-frame or mid-handshake discards pending data. No tick is produced for a `screen_end` that was already high at release.

**Latency** (E = first cycle where `screen_end` = 1 and `se_q` = 0)
- `tick` is high in E+1.
- New bounds are visible in E+2.
- Eval happens in E+2.
- `hold_count`, `game_state` and `win` are visible in E+3.
- `start` → `game_state` = 1 on the next cycle.

**Throughput**
- One target update per frame.
- Bounds change only in the cycle after a tick, which falls inside blanking.

## Test plan

- **Reset and target commit:** hold reset low 3 cycles, release, set player (320,240), offer target (320,240), pulse `screen_end` → `tgt_ready` is 0 in reset and 1 after release. The handshake is accepted, and at E+2 player bounds read 295/345/215/265 and target bounds 290/350/210/270.
- **Clamping:** player (5,470), target (635,2) → player bounds 0/50/429/479, target bounds 579/639/0/60. No wrap.
- **Slot full:** second offer while the slot is full → `tgt_ready` stays 0 until the tick cycle drains the slot. The second value commits one frame later; the first value is never lost.
- **Win:** `start`, then hold player inside target for 60 frames → `hold_count` 1..59, with `win` pulsed and `game_state` = 2 at E+3 of frame 60. A miss at frame 30 instead resets `hold_count` to 0.
- **Restart:** `start` while in WIN → `game_state` = 1, `new_target_req` high for exactly one cycle, `hold_count` = 0.
- **Mid-operation reset:** assert reset with the slot full and `screen_end` high, release while `screen_end` is still high → no tick, bounds stay 0, slot empty. The next rising edge of `screen_end` ticks normally.
